// File: rtl/alu_cmd_seq_if.sv
// Command, result and ALU-side signals of the ALU command sequencer.
// The slave modport is the sequencer's view; master is the command source / ALU side.
interface alu_cmd_seq_if;
    // valid/ready: a transfer happens on a rising clk edge where both valid and ready are
    // high; the sender holds its payload steady while valid is high and ready is low.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_q;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_q;
    logic       res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_q, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_q, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_q, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_q, res_err
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// Sequencer in front of the 8-bit combinational ALU: single ops take one EXEC cycle,
// MUL (op 8) runs 8 iterations of add/shl/shr through the same ALU.
module alu_cmd_seq (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_seq_if.slave     bus,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_MUL_ADD = 3'd2,
        S_MUL_SHL = 3'd3,
        S_MUL_SHR = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SHR  = 3'd2;
    localparam logic [2:0] ALU_SHL  = 3'd3;
    localparam logic [2:0] ALU_IDLE = 3'd6;
    localparam logic [3:0] OP_MUL   = 4'd8;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_op;
    logic [7:0] r_a;      // operand A; doubles as the shifted multiplicand x
    logic [7:0] r_b;      // operand B; doubles as the shifted multiplier y
    logic [7:0] r_acc;
    logic [2:0] r_cnt;
    logic       r_res_valid;
    logic [7:0] r_res_q;
    logic       r_res_err;

    logic       w_accept;
    logic       w_illegal;
    logic       w_cmd_ready;
    logic [7:0] w_alu_a;
    logic [7:0] w_alu_b;
    logic [2:0] w_alu_op;

    assign w_cmd_ready = (r_state == S_IDLE) && !r_res_valid;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_illegal   = r_op[3] && (r_op[2:0] != 3'd0);

    always_comb begin
        w_next   = r_state;
        w_alu_a  = 8'd0;
        w_alu_b  = 8'd0;
        w_alu_op = ALU_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (bus.cmd_op == OP_MUL) ? S_MUL_ADD : S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_a  = r_a;
                w_alu_b  = r_b;
                w_alu_op = w_illegal ? ALU_IDLE : r_op[2:0];
                w_next   = S_IDLE;
            end
            S_MUL_ADD: begin
                w_alu_a  = r_acc;
                w_alu_b  = r_a;
                w_alu_op = ALU_ADD;
                w_next   = S_MUL_SHL;
            end
            S_MUL_SHL: begin
                w_alu_a  = r_a;
                w_alu_op = ALU_SHL;
                w_next   = S_MUL_SHR;
            end
            S_MUL_SHR: begin
                w_alu_a  = r_b;
                w_alu_op = ALU_SHR;
                w_next   = (r_cnt == 3'd7) ? S_IDLE : S_MUL_ADD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 4'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= 8'd0;
            r_cnt       <= 3'd0;
            r_res_valid <= 1'b0;
            r_res_q     <= 8'd0;
            r_res_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // EXEC/MUL captures never coincide with a pending result, so this clear is safe
            if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.cmd_op;
                        r_a   <= bus.cmd_a;
                        r_b   <= bus.cmd_b;
                        r_acc <= 8'd0;
                        r_cnt <= 3'd0;
                    end
                end
                S_EXEC: begin
                    r_res_valid <= 1'b1;
                    r_res_q     <= w_illegal ? 8'd0 : bus.alu_q;
                    r_res_err   <= w_illegal;
                end
                S_MUL_ADD: begin
                    if (r_b[0]) begin
                        r_acc <= bus.alu_q;
                    end
                end
                S_MUL_SHL: r_a <= bus.alu_q;
                S_MUL_SHR: begin
                    r_b   <= bus.alu_q;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_res_valid <= 1'b1;
                        r_res_q     <= r_acc;
                        r_res_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.res_valid = r_res_valid;
    assign bus.res_q     = r_res_q;
    assign bus.res_err   = r_res_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq: a lab4 ALU model closes the loop, a negedge monitor
// checks results against an expected queue, ALU drive per cycle and result latency.
module tb_alu_cmd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    alu_cmd_seq_if bus ();

    alu_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // lab4 ALU: 0 add, 1 sub, 2 shr1, 3 shl1, 4 and, 5 or, 6 xor, 7 not
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: alu_fn = a + b;
            3'd1: alu_fn = a - b;
            3'd2: alu_fn = a >> 1;
            3'd3: alu_fn = a << 1;
            3'd4: alu_fn = a & b;
            3'd5: alu_fn = a | b;
            3'd6: alu_fn = a ^ b;
            default: alu_fn = ~a;
        endcase
    endfunction

    always_comb bus.alu_q = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];      // {err, q}
    int         exp_lat_q[$];  // monitor cycles from acceptance to res_valid rise

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: all inputs change at posedge+1, so negedge sees stable values.
    int         cyc = 0;
    int         acc_cyc = 0;
    int         hs_cyc = 0;
    logic       prev_rv = 1'b0;
    int         trk_left = 0;
    int         trk_idx = 0;
    logic [3:0] trk_op;
    logic [7:0] trk_a;
    logic [7:0] trk_b;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            trk_left = 0;
            prev_rv  = 1'b0;
        end else begin
            if (trk_left > 0) begin
                if (trk_op == 4'd8) begin
                    case (trk_idx % 3)
                        0:       chk("mul_op_add", int'(bus.alu_op), 0);
                        1:       chk("mul_op_shl", int'(bus.alu_op), 3);
                        default: chk("mul_op_shr", int'(bus.alu_op), 2);
                    endcase
                    if (trk_idx % 3 != 0) chk("mul_b_zero", int'(bus.alu_b), 0);
                end else begin
                    chk("exec_a", int'(bus.alu_a), int'(trk_a));
                    chk("exec_b", int'(bus.alu_b), int'(trk_b));
                    chk("exec_op", int'(bus.alu_op), trk_op[3] ? 6 : int'(trk_op[2:0]));
                end
                trk_idx++;
                trk_left--;
            end
            if (bus.res_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    logic [8:0] e;
                    int         lat;
                    e   = exp_q.pop_front();
                    lat = exp_lat_q.pop_front();
                    chk("res_q", int'(bus.res_q), int'(e[7:0]));
                    chk("res_err", int'(bus.res_err), int'(e[8]));
                    chk("latency", cyc - acc_cyc, lat);
                end
            end
            if (bus.res_valid && bus.res_ready) hs_cyc = cyc;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc  = cyc;
                trk_op   = bus.cmd_op;
                trk_a    = bus.cmd_a;
                trk_b    = bus.cmd_b;
                trk_idx  = 0;
                trk_left = (bus.cmd_op == 4'd8) ? 24 : 1;
            end
            prev_rv = bus.res_valid;
        end
    end

    // Driver: present a command until accepted; expected result is queued up front.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic err);
        bit ok = 0;
        exp_q.push_back({err, q});
        exp_lat_q.push_back((op == 4'd8) ? 25 : 2);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        bit seen_rv;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_q", int'(bus.res_q), 0);
        chk("rst_res_err", int'(bus.res_err), 0);
        chk("rst_alu_a", int'(bus.alu_a), 0);
        chk("rst_alu_b", int'(bus.alu_b), 0);
        chk("rst_alu_op", int'(bus.alu_op), 6);

        send(4'd0, 8'd200, 8'd100, 8'd44, 1'b0);    wait_drain();
        send(4'd1, 8'd5, 8'd10, 8'd251, 1'b0);      wait_drain();
        send(4'd4, 8'hF0, 8'h3C, 8'h30, 1'b0);      wait_drain();
        send(4'd8, 8'd13, 8'd11, 8'd143, 1'b0);     wait_drain();
        send(4'd8, 8'd20, 8'd20, 8'd144, 1'b0);     wait_drain();
        send(4'd8, 8'd255, 8'd255, 8'd1, 1'b0);     wait_drain();
        send(4'd12, 8'd7, 8'd9, 8'd0, 1'b1);        wait_drain();

        // Backpressure with a second command waiting on cmd_valid.
        bus.res_ready = 1'b0;
        send(4'd0, 8'd10, 8'd20, 8'd30, 1'b0);
        seen_rv = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen_rv = 1;
                break;
            end
        end
        chk("bp_res_valid_seen", int'(seen_rv), 1);
        fork
            send(4'd1, 8'd50, 8'd8, 8'd42, 1'b0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_res_q_hold", int'(bus.res_q), 30);
                    chk("bp_res_valid_hold", int'(bus.res_valid), 1);
                    chk("bp_cmd_ready_low", int'(bus.cmd_ready), 0);
                end
                @(posedge clk); #1;
                bus.res_ready = 1'b1;
            end
        join
        chk("bp_accept_after_hs", acc_cyc - hs_cyc, 1);
        wait_drain();

        // Reset ten cycles into a MUL: nothing may come out of the aborted operation.
        send(4'd8, 8'd100, 8'd3, 8'd44, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_lat_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("mrst_res_valid", int'(bus.res_valid), 0);
        chk("mrst_res_q", int'(bus.res_q), 0);
        chk("mrst_res_err", int'(bus.res_err), 0);
        chk("mrst_alu_a", int'(bus.alu_a), 0);
        chk("mrst_alu_b", int'(bus.alu_b), 0);
        chk("mrst_alu_op", int'(bus.alu_op), 6);
        seen_rv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen_rv = 1;
        end
        chk("mrst_no_result", int'(seen_rv), 0);
        send(4'd0, 8'd1, 8'd2, 8'd3, 1'b0);         wait_drain();

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end
endmodule
